// File: rtl/array_heap_engine.sv
// array_heap_engine: bank of small arrays with sizes, push/pop and scans.
// One operation at a time; scans walk one element per cycle from plain RAM.
module array_heap_engine #(
  parameter int ADDRESS_BITS = 8,
  parameter int INDEX_BITS   = 3,
  parameter int DATA_BITS    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              action,
  input  logic [ADDRESS_BITS-1:0] array,
  input  logic [INDEX_BITS-1:0]   index,
  input  logic [DATA_BITS-1:0]    in,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_BITS-1:0]    out,
  output logic                    error
);

  localparam int ARRAYS = 2**ADDRESS_BITS;
  localparam int LEN    = 2**INDEX_BITS;
  localparam int AW     = ADDRESS_BITS + INDEX_BITS;

  localparam logic [3:0] OP_CLR  = 4'd0;
  localparam logic [3:0] OP_WR   = 4'd1;
  localparam logic [3:0] OP_RD   = 4'd2;
  localparam logic [3:0] OP_SIZE = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_POP  = 4'd5;
  localparam logic [3:0] OP_GT   = 4'd6;
  localparam logic [3:0] OP_LT   = 4'd7;
  localparam logic [3:0] OP_IDX  = 4'd8;

  typedef logic [INDEX_BITS:0] size_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SCAN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]              op;
  logic [ADDRESS_BITS-1:0] a;
  logic [INDEX_BITS-1:0]   idx;
  logic [DATA_BITS-1:0]    din;
  size_t                   i;
  logic                    pv;
  logic [DATA_BITS-1:0]    cnt, cnt_n;
  size_t                   sizes [ARRAYS];
  size_t                   sz;

  logic [DATA_BITS-1:0]    mem [ARRAYS*LEN];
  logic [DATA_BITS-1:0]    rdata;
  logic [AW-1:0]           raddr, waddr;
  logic [INDEX_BITS-1:0]   pidx;
  logic                    we;
  logic                    idx_ok, full, hit, last, is_scan;

  assign busy = (state == EXEC) || (state == SCAN);
  assign done = (state == DONE);

  // Operand decode for the latched request and the scan compare.
  always_comb begin
    sz      = sizes[a];
    idx_ok  = {1'b0, idx} < sz;
    full    = sz[INDEX_BITS];
    last    = (i == sz);
    hit     = pv && (op == OP_IDX) && (rdata == din);
    is_scan = (action == OP_GT) || (action == OP_LT) ||
              (action == OP_IDX);
    cnt_n   = cnt;
    if (pv && (op == OP_GT) && (rdata > din))
      cnt_n = cnt + DATA_BITS'(1);
    if (pv && (op == OP_LT) && (rdata < din))
      cnt_n = cnt + DATA_BITS'(1);
  end

  // RAM port addressing: Read/Pop fetch on accept, scans fetch element i.
  always_comb begin
    pidx  = sizes[array][INDEX_BITS-1:0] - INDEX_BITS'(1);
    raddr = {a, i[INDEX_BITS-1:0]};
    if (state == IDLE)
      raddr = (action == OP_POP) ? {array, pidx} : {array, index};
    waddr = (op == OP_PUSH) ? {a, sz[INDEX_BITS-1:0]} : {a, idx};
    we    = (state == EXEC) &&
            (((op == OP_WR) && idx_ok) || ((op == OP_PUSH) && !full));
  end

  // Element storage: one write and one registered read port, never reset.
  always_ff @(posedge clock) begin
    if (we)
      mem[waddr] <= din;
    rdata <= mem[raddr];
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = is_scan ? SCAN : EXEC;
      EXEC: state_n = DONE;
      SCAN: if (hit || last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch, array sizes and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op    <= '0;
      a     <= '0;
      idx   <= '0;
      din   <= '0;
      i     <= '0;
      pv    <= 1'b0;
      cnt   <= '0;
      out   <= '0;
      error <= 1'b0;
      for (int k = 0; k < ARRAYS; k++)
        sizes[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op  <= action;
            a   <= array;
            idx <= index;
            din <= in;
            i   <= '0;
            pv  <= 1'b0;
            cnt <= '0;
          end
        end
        EXEC: begin
          out   <= '0;
          error <= 1'b0;
          case (op)
            OP_CLR:  sizes[a] <= '0;
            OP_WR:   if (idx_ok) out <= din;
                     else error <= 1'b1;
            OP_RD:   if (idx_ok) out <= rdata;
                     else error <= 1'b1;
            OP_SIZE: out <= DATA_BITS'(sz);
            OP_PUSH: begin
              if (!full) begin
                sizes[a] <= sz + size_t'(1);
                out      <= DATA_BITS'(sz + size_t'(1));
              end else begin
                error <= 1'b1;
              end
            end
            OP_POP: begin
              if (sz != '0) begin
                sizes[a] <= sz - size_t'(1);
                out      <= rdata;
              end else begin
                error <= 1'b1;
              end
            end
            default: error <= 1'b1;
          endcase
        end
        SCAN: begin
          cnt <= cnt_n;
          if (hit) begin
            out   <= DATA_BITS'(i - size_t'(1));
            error <= 1'b0;
          end else if (last) begin
            out   <= (op == OP_IDX) ? '0 : cnt_n;
            error <= (op == OP_IDX);
          end else begin
            i  <= i + size_t'(1);
            pv <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_array_heap_engine.sv
// tb_array_heap_engine: directed checks of array_heap_engine with N=4.
// Four arrays of four 12-bit elements.
module tb_array_heap_engine;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  action;
  logic [1:0]  array;
  logic [1:0]  index;
  logic [11:0] in;
  logic        busy;
  logic        done;
  logic [11:0] out;
  logic        error;

  int checks = 0;
  int errors = 0;

  array_heap_engine #(
    .ADDRESS_BITS(2),
    .INDEX_BITS(2),
    .DATA_BITS(12)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .action(action),
    .array(array),
    .index(index),
    .in(in),
    .busy(busy),
    .done(done),
    .out(out),
    .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // lat = number of edges after the accepting edge until done is sampled
  task automatic run(input logic [3:0] act, input logic [1:0] arr,
                     input logic [1:0] idx, input logic [11:0] d,
                     output logic [11:0] o, output logic e,
                     output int lat);
    int k;
    @(negedge clock);
    start = 1'b1; action = act; array = arr; index = idx; in = d;
    @(posedge clock);
    #1 start = 1'b0;
    k = 0;
    lat = 0;
    while (lat == 0 && k < 40) begin
      @(negedge clock);
      k++;
      if (done) lat = k;
    end
    o = out;
    e = error;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL timeout act=%0d arr=%0d got no done, need done", act, arr);
    end
  endtask

  task automatic test_reset();
    logic [11:0] o; logic e; int lat;
    int bad;
    reset = 1'b0; start = 1'b0; action = '0; array = '0;
    index = '0; in = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 12'd0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs busy=%b done=%b out=%0d err=%b need 0", busy, done, out, error);
    end
    reset = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_busy high %0d cycles need 0", bad);
    end
    for (int j = 0; j < 4; j++) begin
      run(4'd3, 2'(j), 2'd0, 12'd0, o, e, lat);
      checks++;
      if (o !== 12'd0 || e !== 1'b0 || lat != 2) begin
        errors++;
        $display("FAIL size_init arr=%0d out=%0d err=%b lat=%0d need 0 0 2", j, o, e, lat);
      end
    end
  endtask

  task automatic test_push_read_write();
    logic [11:0] o; logic e; int lat;
    logic [11:0] vals [3] = '{12'd5, 12'd9, 12'd3};
    for (int j = 0; j < 3; j++) begin
      run(4'd4, 2'd1, 2'd0, vals[j], o, e, lat);
      checks++;
      if (o !== 12'(j + 1) || e !== 1'b0 || lat != 2) begin
        errors++;
        $display("FAIL push%0d out=%0d err=%b lat=%0d need %0d 0 2", j, o, e, lat, j + 1);
      end
    end
    run(4'd2, 2'd1, 2'd1, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd9 || e !== 1'b0) begin
      errors++;
      $display("FAIL read1 out=%0d err=%b need 9 0", o, e);
    end
    run(4'd2, 2'd1, 2'd3, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 1'b1) begin
      errors++;
      $display("FAIL read_oob out=%0d err=%b need 0 1", o, e);
    end
    run(4'd1, 2'd1, 2'd2, 12'd7, o, e, lat);
    checks++;
    if (o !== 12'd7 || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL write2 out=%0d err=%b lat=%0d need 7 0 2", o, e, lat);
    end
    run(4'd2, 2'd1, 2'd2, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd7 || e !== 1'b0) begin
      errors++;
      $display("FAIL read2 out=%0d err=%b need 7 0", o, e);
    end
  endtask

  task automatic test_scan();
    logic [11:0] o; logic e; int lat;
    run(4'd6, 2'd1, 2'd0, 12'd6, o, e, lat);
    checks++;
    if (o !== 12'd2 || e !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL greater out=%0d err=%b lat=%0d need 2 0 5", o, e, lat);
    end
    run(4'd7, 2'd1, 2'd0, 12'd6, o, e, lat);
    checks++;
    if (o !== 12'd1 || e !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL less out=%0d err=%b lat=%0d need 1 0 5", o, e, lat);
    end
    run(4'd8, 2'd1, 2'd0, 12'd9, o, e, lat);
    checks++;
    if (o !== 12'd1 || e !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL index_hit out=%0d err=%b lat=%0d need 1 0 4", o, e, lat);
    end
    run(4'd8, 2'd1, 2'd0, 12'd4, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 1'b1 || lat != 5) begin
      errors++;
      $display("FAIL index_miss out=%0d err=%b lat=%0d need 0 1 5", o, e, lat);
    end
  endtask

  task automatic test_full_empty();
    logic [11:0] o; logic e; int lat;
    logic [11:0] vals [4] = '{12'd10, 12'd20, 12'd30, 12'd40};
    for (int j = 0; j < 4; j++) run(4'd4, 2'd2, 2'd0, vals[j], o, e, lat);
    checks++;
    if (o !== 12'd4 || e !== 1'b0) begin
      errors++;
      $display("FAIL push4 out=%0d err=%b need 4 0", o, e);
    end
    run(4'd4, 2'd2, 2'd0, 12'd50, o, e, lat);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL push_full err=%b need 1", e);
    end
    run(4'd3, 2'd2, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd4 || e !== 1'b0) begin
      errors++;
      $display("FAIL size_full out=%0d err=%b need 4 0", o, e);
    end
    run(4'd6, 2'd2, 2'd0, 12'd15, o, e, lat);
    checks++;
    if (o !== 12'd3 || e !== 1'b0 || lat != 6) begin
      errors++;
      $display("FAIL greater_full out=%0d err=%b lat=%0d need 3 0 6", o, e, lat);
    end
    for (int j = 3; j >= 0; j--) begin
      run(4'd5, 2'd2, 2'd0, 12'd0, o, e, lat);
      checks++;
      if (o !== vals[j] || e !== 1'b0) begin
        errors++;
        $display("FAIL pop%0d out=%0d err=%b need %0d 0", j, o, e, vals[j]);
      end
    end
    run(4'd5, 2'd2, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty out=%0d err=%b need 0 1", o, e);
    end
    run(4'd3, 2'd1, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd3 || e !== 1'b0) begin
      errors++;
      $display("FAIL arr1_size out=%0d err=%b need 3 0", o, e);
    end
  endtask

  task automatic test_busy_ignore();
    logic [11:0] o; logic e; int lat;
    int pulses;
    logic [11:0] res;
    @(negedge clock);
    start = 1'b1; action = 4'd6; array = 2'd1; index = 2'd0; in = 12'd6;
    @(posedge clock);
    #1 action = 4'd0;
    repeat (2) @(posedge clock);
    #1 start = 1'b0;
    pulses = 0;
    res = '0;
    repeat (12) begin
      @(negedge clock);
      if (done) begin
        pulses++;
        res = out;
      end
    end
    checks++;
    if (pulses != 1 || res !== 12'd2) begin
      errors++;
      $display("FAIL busy_ignore pulses=%0d out=%0d need 1 2", pulses, res);
    end
    run(4'd3, 2'd1, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd3) begin
      errors++;
      $display("FAIL ignored_clear size=%0d need 3", o);
    end
  endtask

  task automatic test_illegal_clear();
    logic [11:0] o; logic e; int lat;
    run(4'd12, 2'd1, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 1'b1 || lat != 2) begin
      errors++;
      $display("FAIL illegal out=%0d err=%b lat=%0d need 0 1 2", o, e, lat);
    end
    run(4'd0, 2'd1, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 1'b0) begin
      errors++;
      $display("FAIL clear out=%0d err=%b need 0 0", o, e);
    end
    run(4'd3, 2'd1, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd0) begin
      errors++;
      $display("FAIL clear_size out=%0d need 0", o);
    end
    run(4'd6, 2'd1, 2'd0, 12'd0, o, e, lat);
    checks++;
    if (o !== 12'd0 || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL greater_empty out=%0d err=%b lat=%0d need 0 0 2", o, e, lat);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [11:0] o; logic e; int lat;
    int pulses;
    run(4'd4, 2'd3, 2'd0, 12'd1, o, e, lat);
    run(4'd4, 2'd3, 2'd0, 12'd2, o, e, lat);
    @(negedge clock);
    start = 1'b1; action = 4'd6; array = 2'd3; in = 12'd0;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b need 0 0", busy, done);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL aborted_done pulses=%0d need 0", pulses);
    end
    for (int j = 0; j < 4; j++) begin
      run(4'd3, 2'(j), 2'd0, 12'd0, o, e, lat);
      checks++;
      if (o !== 12'd0 || e !== 1'b0) begin
        errors++;
        $display("FAIL size_after_reset arr=%0d out=%0d err=%b need 0 0", j, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_read_write();
    test_scan();
    test_full_empty();
    test_busy_ignore();
    test_illegal_clear();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
